// File: rtl/stream_select_arbiter.sv
// Round-robin arbiter with packet lock that drives the selector of a 4-to-1 stream multiplexer.
// Optional stall watchdog is compiled in when ARB_WATCHDOG_EN is defined.
module stream_select_arbiter #(
   parameter int         LOCK_PACKETS = 1,
   parameter logic [1:0] RR_INIT      = 2'd0,
   parameter int         MAX_HOLD     = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req_valid,
   input  logic [3:0] req_last,
   output logic [3:0] req_ready,
   output logic [1:0] selector,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready,
   output logic       busy
`ifdef ARB_WATCHDOG_EN
   ,
   output logic       wd_timeout
`endif
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam logic LOCK_EN = (LOCK_PACKETS != 0);

   state_t     state_r;
   logic [1:0] selector_r;
   logic [1:0] rr_ptr_r;
   logic       busy_r;

   logic       xfer_s;
   logic       release_s;
   logic       drop_s;
   logic       any_req_s;
   logic [1:0] next_ptr_s;
   logic [1:0] arb_ptr_s;
   logic [1:0] grant_s;

   // First requesting channel at or after ptr, wrapping 3->0.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] pick;
      logic [1:0] idx;
      logic       found;
      pick  = ptr;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return pick;
   endfunction

   // Handshake steering: only the granted channel sees the consumer's ready.
   always_comb begin
      req_ready = 4'b0000;
      out_valid = 1'b0;
      out_last  = 1'b0;
      if (state_r == BURST) begin
         out_valid             = req_valid[selector_r];
         out_last              = req_last[selector_r];
         req_ready[selector_r] = out_ready;
      end else begin
         req_ready = 4'b0000;
      end
   end

   assign xfer_s     = (state_r == BURST) && req_valid[selector_r] && out_ready;
   assign release_s  = xfer_s && (req_last[selector_r] || !LOCK_EN);
   assign any_req_s  = |req_valid;
   assign next_ptr_s = selector_r + 2'd1;
   assign arb_ptr_s  = (state_r == BURST) ? next_ptr_s : rr_ptr_r;
   assign grant_s    = rr_pick(req_valid, arb_ptr_s);

`ifdef ARB_WATCHDOG_EN
   localparam int WD_W = $clog2(MAX_HOLD + 1);

   logic [WD_W-1:0] wd_cnt_r;
   logic            wd_timeout_r;
   logic            wd_fire_s;

   // Fires on the MAX_HOLD-th consecutive stalled grant cycle.
   assign wd_fire_s = (state_r == BURST) && !xfer_s && (wd_cnt_r == WD_W'(MAX_HOLD - 1));
   assign drop_s    = release_s || wd_fire_s;

   // Stall counter and one-cycle timeout pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_r     <= '0;
         wd_timeout_r <= 1'b0;
      end else begin
         wd_timeout_r <= wd_fire_s;
         if ((state_r != BURST) || xfer_s || drop_s) begin
            wd_cnt_r <= '0;
         end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
         end
      end
   end

   assign wd_timeout = wd_timeout_r;
`else
   logic wd_unused_s;

   assign wd_unused_s = (MAX_HOLD > 0);
   assign drop_s      = release_s;
`endif

   // Grant FSM: selector only moves on entry from IDLE or on a release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         selector_r <= 2'b00;
         rr_ptr_r   <= RR_INIT;
         busy_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (any_req_s) begin
                  selector_r <= grant_s;
                  state_r    <= BURST;
                  busy_r     <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            BURST: begin
               if (drop_s) begin
                  rr_ptr_r <= next_ptr_s;
                  if (any_req_s) begin
                     selector_r <= grant_s;
                     state_r    <= BURST;
                     busy_r     <= 1'b1;
                  end else begin
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  state_r <= BURST;
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign selector = selector_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_stream_select_arbiter.sv
// Table-driven bench for stream_select_arbiter: locked and unlocked instances, plus a
// MAX_HOLD=4 watchdog instance when ARB_WATCHDOG_EN is defined.
module tb_stream_select_arbiter;

   typedef struct packed {
      logic       rst;
      logic [3:0] valid;
      logic [3:0] last;
      logic       ordy;
      logic [1:0] sel;
      logic [3:0] ready;
      logic       ov;
      logic       ol;
      logic       busy;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;

   logic [3:0] v1, l1, rd1, v2, l2, rd2;
   logic       r1, r2, ov1, ol1, b1, ov2, ol2, b2;
   logic [1:0] s1, s2;
`ifdef ARB_WATCHDOG_EN
   logic [3:0] v3, l3, rd3;
   logic       r3, ov3, ol3, b3, wd1, wd2, wd3;
   logic [1:0] s3;
`endif

   logic [9:0] exp_q[$];
   vec_t       main_q[$];
   vec_t       nolock_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   stream_select_arbiter #(.LOCK_PACKETS(1), .RR_INIT(2'd0)) dut_lock (
      .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_last(l1), .req_ready(rd1),
      .selector(s1), .out_valid(ov1), .out_last(ol1), .out_ready(r1), .busy(b1)
`ifdef ARB_WATCHDOG_EN
      , .wd_timeout(wd1)
`endif
   );

   stream_select_arbiter #(.LOCK_PACKETS(0), .RR_INIT(2'd0)) dut_nolock (
      .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_last(l2), .req_ready(rd2),
      .selector(s2), .out_valid(ov2), .out_last(ol2), .out_ready(r2), .busy(b2)
`ifdef ARB_WATCHDOG_EN
      , .wd_timeout(wd2)
`endif
   );

`ifdef ARB_WATCHDOG_EN
   stream_select_arbiter #(.LOCK_PACKETS(1), .RR_INIT(2'd0), .MAX_HOLD(4)) dut_wd (
      .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_last(l3), .req_ready(rd3),
      .selector(s3), .out_valid(ov3), .out_last(ol3), .out_ready(r3), .busy(b3),
      .wd_timeout(wd3)
   );
`endif

   function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                               input logic o, input logic [1:0] s, input logic [3:0] rd,
                               input logic ov, input logic ol, input logic b);
      vec_t t;
      t.rst = r; t.valid = v; t.last = l; t.ordy = o;
      t.sel = s; t.ready = rd; t.ov = ov; t.ol = ol; t.busy = b;
      return t;
   endfunction

   // Drive one cycle on the chosen instance, queue the expectation, check mid-low-phase.
   task automatic run(input int which, input vec_t v, input logic ewd,
                      input string name, input int idx);
      logic [9:0] got_v;
      logic [9:0] exp_v;
      @(negedge clk);
      rst_n = v.rst;
      got_v = '0;
      case (which)
         1: begin v1 = v.valid; l1 = v.last; r1 = v.ordy; end
         2: begin v2 = v.valid; l2 = v.last; r2 = v.ordy; end
`ifdef ARB_WATCHDOG_EN
         3: begin v3 = v.valid; l3 = v.last; r3 = v.ordy; end
`endif
         default: begin end
      endcase
      exp_q.push_back({v.sel, v.ready, v.ov, v.ol, v.busy, ewd});
      #1;
      case (which)
         1: got_v = {s1, rd1, ov1, ol1, b1, 1'b0};
         2: got_v = {s2, rd2, ov2, ol2, b2, 1'b0};
`ifdef ARB_WATCHDOG_EN
         3: got_v = {s3, rd3, ov3, ol3, b3, wd3};
`endif
         default: got_v = '1;
      endcase
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
         n_bad++;
         $display("FAIL %s[%0d] got sel=%0d ready=%b ov=%b ol=%b busy=%b wd=%b required sel=%0d ready=%b ov=%b ol=%b busy=%b wd=%b",
                  name, idx, got_v[9:8], got_v[7:4], got_v[3], got_v[2], got_v[1], got_v[0],
                  exp_v[9:8], exp_v[7:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      v1 = 4'h0; l1 = 4'h0; r1 = 1'b0;
      v2 = 4'h0; l2 = 4'h0; r2 = 1'b0;
`ifdef ARB_WATCHDOG_EN
      v3 = 4'h0; l3 = 4'h0; r3 = 1'b0;
`endif

      // Reset with all channels requesting, then one idle cycle before chan 0's grant
      main_q.push_back(mk(1'b0, 4'hF, 4'hF, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
      main_q.push_back(mk(1'b1, 4'hF, 4'hF, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 8; i++)
         main_q.push_back(mk(1'b1, 4'hF, 4'hF, 1'b1, 2'(i % 4), 4'(1 << (i % 4)), 1'b1, 1'b1, 1'b1));
      main_q.push_back(mk(1'b1, 4'h1, 4'h1, 1'b1, 2'd0, 4'h1, 1'b1, 1'b1, 1'b1));
      main_q.push_back(mk(1'b1, 4'h6, 4'h1, 1'b1, 2'd0, 4'h1, 1'b0, 1'b1, 1'b1));
      main_q.push_back(mk(1'b1, 4'h5, 4'h1, 1'b1, 2'd0, 4'h1, 1'b1, 1'b1, 1'b1));
      // Chan 2 three-beat packet while chan 1 waits
      main_q.push_back(mk(1'b1, 4'h6, 4'h0, 1'b1, 2'd2, 4'h4, 1'b1, 1'b0, 1'b1));
      main_q.push_back(mk(1'b1, 4'h6, 4'h0, 1'b1, 2'd2, 4'h4, 1'b1, 1'b0, 1'b1));
      main_q.push_back(mk(1'b1, 4'h6, 4'h4, 1'b1, 2'd2, 4'h4, 1'b1, 1'b1, 1'b1));
      main_q.push_back(mk(1'b1, 4'h2, 4'h2, 1'b1, 2'd1, 4'h2, 1'b1, 1'b1, 1'b1));
      main_q.push_back(mk(1'b1, 4'hA, 4'h2, 1'b1, 2'd1, 4'h2, 1'b1, 1'b1, 1'b1));
      // Chan 3 drops valid mid-packet for 5 cycles while chan 0 requests
      main_q.push_back(mk(1'b1, 4'h8, 4'h0, 1'b1, 2'd3, 4'h8, 1'b1, 1'b0, 1'b1));
      for (int i = 0; i < 5; i++)
         main_q.push_back(mk(1'b1, 4'h1, 4'h0, 1'b1, 2'd3, 4'h8, 1'b0, 1'b0, 1'b1));
      main_q.push_back(mk(1'b1, 4'hC, 4'h8, 1'b1, 2'd3, 4'h8, 1'b1, 1'b1, 1'b1));
      // Ten stalled cycles on chan 2, then an asynchronous reset pulse
      for (int i = 0; i < 10; i++)
         main_q.push_back(mk(1'b1, 4'h4, 4'h0, 1'b0, 2'd2, 4'h0, 1'b1, 1'b0, 1'b1));
      main_q.push_back(mk(1'b0, 4'h4, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
      main_q.push_back(mk(1'b1, 4'h0, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
      main_q.push_back(mk(1'b1, 4'h4, 4'h4, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
      main_q.push_back(mk(1'b1, 4'h4, 4'h4, 1'b1, 2'd2, 4'h4, 1'b1, 1'b1, 1'b1));

      // Unlocked: chan 2's packet interleaves with chan 1 beat by beat
      nolock_q.push_back(mk(1'b1, 4'h2, 4'h2, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0));
      nolock_q.push_back(mk(1'b1, 4'h6, 4'h2, 1'b1, 2'd1, 4'h2, 1'b1, 1'b1, 1'b1));
      nolock_q.push_back(mk(1'b1, 4'h6, 4'h0, 1'b1, 2'd2, 4'h4, 1'b1, 1'b0, 1'b1));
      nolock_q.push_back(mk(1'b1, 4'h6, 4'h0, 1'b1, 2'd1, 4'h2, 1'b1, 1'b0, 1'b1));
      nolock_q.push_back(mk(1'b1, 4'h6, 4'h0, 1'b1, 2'd2, 4'h4, 1'b1, 1'b0, 1'b1));
      nolock_q.push_back(mk(1'b1, 4'h6, 4'h0, 1'b1, 2'd1, 4'h2, 1'b1, 1'b0, 1'b1));
      nolock_q.push_back(mk(1'b1, 4'h6, 4'h4, 1'b1, 2'd2, 4'h4, 1'b1, 1'b1, 1'b1));
      nolock_q.push_back(mk(1'b1, 4'h2, 4'h2, 1'b1, 2'd1, 4'h2, 1'b1, 1'b1, 1'b1));
      nolock_q.push_back(mk(1'b1, 4'h0, 4'h0, 1'b1, 2'd1, 4'h2, 1'b0, 1'b0, 1'b1));

      foreach (main_q[i])   run(1, main_q[i], 1'b0, "lock", i);
      foreach (nolock_q[i]) run(2, nolock_q[i], 1'b0, "nolock", i);

`ifdef ARB_WATCHDOG_EN
      // Chan 1 stalls four cycles; the watchdog releases it and chan 2 takes over
      run(3, mk(1'b1, 4'h2, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0), 1'b0, "wd", 0);
      for (int i = 1; i <= 4; i++)
         run(3, mk(1'b1, 4'h6, 4'h0, 1'b0, 2'd1, 4'h0, 1'b1, 1'b0, 1'b1), 1'b0, "wd", i);
      run(3, mk(1'b1, 4'h6, 4'h0, 1'b0, 2'd2, 4'h0, 1'b1, 1'b0, 1'b1), 1'b1, "wd", 5);
      run(3, mk(1'b1, 4'h6, 4'h4, 1'b1, 2'd2, 4'h4, 1'b1, 1'b1, 1'b1), 1'b0, "wd", 6);
`endif

      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
